conv_ctrl_axil_slave: RTL and testbench

//  AXI4-Lite responder holding the PS-visible control/config registers of the PL conv accelerator.

---
 rtl/conv_acc_axil_pkg.sv | 37 +++
 rtl/conv_reg_bank.sv | 52 +++++
 rtl/conv_ctrl_axil_slave.sv | 175 +++++++++++++++++
 tb/tb_conv_ctrl_axil_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_axil_pkg.sv
// rtl/conv_acc_axil_pkg.sv - shared response codes, register map and FSM state types for the conv control slave
package conv_acc_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int REG_CTRL     = 0;
  localparam int REG_IFM_ADDR = 1;
  localparam int REG_OFM_ADDR = 2;
  localparam int REG_SHAPE    = 3;

  typedef enum logic [2:0] {
    WR_INIT,
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_INIT,
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_reg_bank.sv
// rtl/conv_reg_bank.sv - register storage with optional byte-masked write (AXIL_SLV_WSTRB_EN) and read mux
module conv_reg_bank
  import conv_acc_axil_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int IDX_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [IDX_WIDTH-1:0]     wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  input  logic [IDX_WIDTH-1:0]     rd_idx,
  output logic [NUM_REGS*32-1:0]   regs,
  output logic [31:0]              rd_data
);

  logic [31:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (int'(wr_idx) == k) begin
`ifdef AXIL_SLV_WSTRB_EN
          mem[k] <= byte_merge(mem[k], wr_data, wr_strb);
`else
          mem[k] <= wr_data;
`endif
        end
      end
    end
  end

`ifndef AXIL_SLV_WSTRB_EN
  logic unused_strb;
  assign unused_strb = ^wr_strb;
`endif

  // Indices past NUM_REGS fall through to zero.
  always_comb begin
    regs    = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs[32*k +: 32] = mem[k];
      if (int'(rd_idx) == k) rd_data = mem[k];
    end
  end

endmodule

// File: rtl/conv_ctrl_axil_slave.sv
// rtl/conv_ctrl_axil_slave.sv - AXI4-Lite control register slave; byte strobes honoured when AXIL_SLV_WSTRB_EN is defined
module conv_ctrl_axil_slave
  import conv_acc_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]    regs_o,
  output logic [NUM_REGS-1:0]       reg_wr_o
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                   awready, wready, bvalid, arready, rvalid;
  logic                   aw_hs, w_hs, ar_hs, commit;
  logic [IDX_WIDTH-1:0]   aw_idx_q, wr_idx, ar_idx;
  logic [DATA_WIDTH-1:0]  w_data_q, wr_data;
  logic [3:0]             w_strb_q, wr_strb;
  logic                   wr_in_range, rd_in_range;
  logic [1:0]             bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]  rdata_q, bank_rd_data;
  logic [NUM_REGS-1:0]    reg_wr_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // WR_INIT keeps both READYs low for the first cycle out of reset.
  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      WR_INIT: wr_next = WR_IDLE;
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = WR_RESP;
        else if (S_AXI_AWVALID)            wr_next = WR_HAVE_AW;
        else if (S_AXI_WVALID)             wr_next = WR_HAVE_W;
      end
      WR_HAVE_AW: begin
        wready = 1'b1;
        if (S_AXI_WVALID) wr_next = WR_RESP;
      end
      WR_HAVE_W: begin
        awready = 1'b1;
        if (S_AXI_AWVALID) wr_next = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_INIT;
    endcase
  end

  assign aw_hs       = S_AXI_AWVALID && awready;
  assign w_hs        = S_AXI_WVALID && wready;
  assign commit      = (wr_state != WR_RESP) && (wr_next == WR_RESP);
  assign wr_idx      = aw_hs ? S_AXI_AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data     = w_hs ? S_AXI_WDATA : w_data_q;
  assign wr_strb     = w_hs ? S_AXI_WSTRB : w_strb_q;
  assign wr_in_range = int'(wr_idx) < NUM_REGS;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= WR_INIT;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= AXI_RESP_OKAY;
      reg_wr_q <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_wr_q[k] <= commit && wr_in_range && (int'(wr_idx) == k);
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      RD_INIT: rd_next = RD_IDLE;
      RD_IDLE: begin
        arready = 1'b1;
        if (S_AXI_ARVALID) rd_next = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (S_AXI_RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_INIT;
    endcase
  end

  assign ar_hs       = S_AXI_ARVALID && arready;
  assign ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign rd_in_range = int'(ar_idx) < NUM_REGS;

  // Read data is sampled from the bank before this edge's write lands, so a same-edge write returns the old value.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state <= RD_INIT;
      rdata_q  <= '0;
      rresp_q  <= AXI_RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? bank_rd_data : '0;
        rresp_q <= rd_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

  conv_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_reg_bank (
    .clk     (ACLK),
    .resetn  (ARESETN),
    .wr_en   (commit && wr_in_range),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_idx  (ar_idx),
    .regs    (regs_o),
    .rd_data (bank_rd_data)
  );

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_o      = reg_wr_q;

endmodule

// File: tb/tb_conv_ctrl_axil_slave.sv
// tb/tb_conv_ctrl_axil_slave.sv - self-checking bench for conv_ctrl_axil_slave; expectations follow AXIL_SLV_WSTRB_EN
module tb_conv_ctrl_axil_slave;
  import conv_acc_axil_pkg::*;

  localparam int NREG = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [5:0]        S_AXI_AWADDR = '0;
  logic [2:0]        S_AXI_AWPROT = '0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA = '0;
  logic [3:0]        S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b0;
  logic [5:0]        S_AXI_ARADDR = '0;
  logic [2:0]        S_AXI_ARPROT = '0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b0;
  logic [NREG*32-1:0] regs_o;
  logic [NREG-1:0]   reg_wr_o;

  conv_ctrl_axil_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(NREG)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o), .reg_wr_o(reg_wr_o)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model [NREG];

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] mask;
`ifdef AXIL_SLV_WSTRB_EN
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
    mask = 32'hFFFF_FFFF;
`endif
    return (old_w & ~mask) | (d & mask);
  endfunction

  function automatic logic [NREG*32-1:0] packed_model();
    logic [NREG*32-1:0] r;
    for (int k = 0; k < NREG; k++) r[32*k +: 32] = model[k];
    return r;
  endfunction

  function automatic logic [NREG-1:0] exp_onehot(input int idx);
    logic [NREG-1:0] r;
    r = '0;
    if (idx < NREG) r[idx] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input int aw_dly, input int w_dly, input int bhold);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    int idx;
    idx = int'(addr[5:2]);
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    S_AXI_BREADY = 1'b0;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      if (aw_done && !w_done) check("held_awready", S_AXI_AWREADY, 0);
      if (w_done && !aw_done) check("held_wready", S_AXI_WREADY, 0);
      if (aw_done != w_done) check("bvalid_before_pair", S_AXI_BVALID, 0);
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("write_handshakes", {aw_done, w_done}, 2'b11);
    if (idx < NREG) model[idx] = model_merge(model[idx], data, strb);
    check("bvalid_latency", S_AXI_BVALID, 1);
    check("bresp", S_AXI_BRESP, exp_resp);
    check("reg_wr_pulse", reg_wr_o, exp_onehot(idx));
    check("regs_after_write", regs_o, packed_model());
    for (int i = 0; i < bhold; i++) begin
      step();
      check("bvalid_held", S_AXI_BVALID, 1);
      check("bresp_held", S_AXI_BRESP, exp_resp);
      check("awready_blocked", S_AXI_AWREADY, 0);
      check("wready_blocked", S_AXI_WREADY, 0);
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", S_AXI_BVALID, 0);
    check("reg_wr_cleared", reg_wr_o, 0);
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int rhold);
    int cyc;
    bit fired, fire_now;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b0;
    cyc = 0; fired = 0;
    while (!fired && cyc < 100) begin
      fire_now = S_AXI_ARREADY;
      step();
      cyc++;
      fired = fire_now;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_handshake", fired, 1);
    check("rvalid_latency", S_AXI_RVALID, 1);
    check("rdata", S_AXI_RDATA, exp_data);
    check("rresp", S_AXI_RRESP, exp_resp);
    for (int i = 0; i < rhold; i++) begin
      step();
      check("rvalid_held", S_AXI_RVALID, 1);
      check("rdata_held", S_AXI_RDATA, exp_data);
      check("rresp_held", S_AXI_RRESP, exp_resp);
      check("arready_blocked", S_AXI_ARREADY, 0);
    end
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
    check("rvalid_cleared", S_AXI_RVALID, 0);
    check("arready_back", S_AXI_ARREADY, 1);
  endtask

  task automatic model_read(input logic [5:0] addr, input int rhold);
    int idx;
    idx = int'(addr[5:2]);
    if (idx < NREG) do_read(addr, model[idx], AXI_RESP_OKAY, rhold);
    else            do_read(addr, 32'h0, AXI_RESP_SLVERR, rhold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_val;
    logic [5:0]  r_addr;
    int          r_idx;

    for (int k = 0; k < NREG; k++) model[k] = '0;

    vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001, AXI_RESP_OKAY,   32'h0};
    vecs[1]  = '{1'b1, 6'h04, 32'h0000_0002, AXI_RESP_OKAY,   32'h0};
    vecs[2]  = '{1'b1, 6'h08, 32'h0000_0003, AXI_RESP_OKAY,   32'h0};
    vecs[3]  = '{1'b1, 6'h0C, 32'h0000_0004, AXI_RESP_OKAY,   32'h0};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,         AXI_RESP_OKAY,   32'h0000_0001};
    vecs[5]  = '{1'b0, 6'h04, 32'h0,         AXI_RESP_OKAY,   32'h0000_0002};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,         AXI_RESP_OKAY,   32'h0000_0003};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0,         AXI_RESP_OKAY,   32'h0000_0004};
    vecs[8]  = '{1'b1, 6'h10, 32'hDEAD_BEEF, AXI_RESP_SLVERR, 32'h0};
    vecs[9]  = '{1'b0, 6'h10, 32'h0,         AXI_RESP_SLVERR, 32'h0};
    vecs[10] = '{1'b0, 6'h3C, 32'h0,         AXI_RESP_SLVERR, 32'h0};
    vecs[11] = '{1'b0, 6'h07, 32'h0,         AXI_RESP_OKAY,   32'h0000_0002};
    vecs[12] = '{1'b1, 6'h0E, 32'h0000_0055, AXI_RESP_OKAY,   32'h0};
    vecs[13] = '{1'b0, 6'h0C, 32'h0,         AXI_RESP_OKAY,   32'h0000_0055};
    vecs[14] = '{1'b0, 6'h00, 32'h0,         AXI_RESP_OKAY,   32'h0000_0001};

    // Reset held for 20 cycles
    ARESETN = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_bresp_rresp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_regs", regs_o, 0);
    check("rst_reg_wr", reg_wr_o, 0);
    ARESETN = 1'b1;
    check("release_ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    step();
    check("release_ready_first_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, 4'hF, vecs[i].exp_resp, 0, 0, 0);
      else               do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp, 0);
    end
    check("regs_after_table", regs_o, {32'h55, 32'h3, 32'h2, 32'h1});

    // AW leads W by 3 cycles, then W leads AW by 3 cycles
    do_write(6'h04, 32'hA5A5_0001, 4'hF, AXI_RESP_OKAY, 0, 3, 0);
    do_write(6'h08, 32'h5A5A_0002, 4'hF, AXI_RESP_OKAY, 3, 0, 0);
    do_read(6'h04, 32'hA5A5_0001, AXI_RESP_OKAY, 0);
    do_read(6'h08, 32'h5A5A_0002, AXI_RESP_OKAY, 0);

    // Backpressure on B and R
    do_write(6'h0C, 32'hCAFE_F00D, 4'hF, AXI_RESP_OKAY, 0, 0, 10);
    do_read(6'h0C, 32'hCAFE_F00D, AXI_RESP_OKAY, 10);

    // Byte strobes
    do_write(6'h00, 32'h1122_3344, 4'hF, AXI_RESP_OKAY, 0, 0, 0);
    do_write(6'h00, 32'hAABB_CCDD, 4'b0101, AXI_RESP_OKAY, 1, 0, 0);
`ifdef AXIL_SLV_WSTRB_EN
    do_read(6'h00, 32'h11BB_33DD, AXI_RESP_OKAY, 0);
`else
    do_read(6'h00, 32'hAABB_CCDD, AXI_RESP_OKAY, 0);
`endif

    // Read and write to the same register on the same edge returns the old value
    old_val = model[0];
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h00;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    check("simul_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model[0] = model_merge(model[0], 32'h0BAD_F00D, 4'hF);
    check("simul_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("simul_rdata_old", S_AXI_RDATA, old_val);
    check("simul_regs_new", regs_o, packed_model());
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    check("simul_cleared", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      r_addr = 6'($urandom_range(0, 63));
      r_idx  = int'(r_addr[5:2]);
      if ($urandom_range(0, 1) == 1)
        do_write(r_addr, $urandom, 4'($urandom_range(0, 15)),
                 (r_idx < NREG) ? AXI_RESP_OKAY : AXI_RESP_SLVERR,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        model_read(r_addr, $urandom_range(0, 2));
    end
    for (int k = 0; k < NREG; k++) model_read(6'(4 * k), 0);

    // Reset while an AW is held: the latch must be discarded
    S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    ARESETN = 1'b0;
    step();
    step();
    ARESETN = 1'b1;
    for (int k = 0; k < NREG; k++) model[k] = '0;
    check("midrst_bvalid", S_AXI_BVALID, 0);
    check("midrst_regs", regs_o, 0);
    step();
    check("midrst_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    do_write(6'h08, 32'h1357_9BDF, 4'hF, AXI_RESP_OKAY, 2, 0, 0);
    model_read(6'h00, 0);
    model_read(6'h08, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
